// File: rtl/stage_1_multi_if.sv
// Operand/result handshake bundle between the CORDIC front-end stage and its neighbours.
// The master drives operands and accepts results; the slave is the stage itself.
interface stage_1_multi_if #(
  parameter int FLT_DATA_WIDTH = 32,
  parameter int NUM_CH         = 2
);
  logic                             in_valid;
  logic                             in_ready;
  logic [NUM_CH*FLT_DATA_WIDTH-1:0] x_in;
  logic                             out_valid;
  logic                             out_ready;
  logic [NUM_CH*FLT_DATA_WIDTH-1:0] out_x;
  logic [NUM_CH*FLT_DATA_WIDTH-1:0] out_half;
  logic [NUM_CH*FLT_DATA_WIDTH-1:0] out_square;
  logic                             timeout;

  modport master (
    output in_valid, x_in, out_ready,
    input  in_ready, out_valid, out_x, out_half, out_square, timeout
  );

  modport slave (
    input  in_valid, x_in, out_ready,
    output in_ready, out_valid, out_x, out_half, out_square, timeout
  );
endinterface

// File: rtl/stage_1_multi.sv
// CORDIC final-adder front end: fans operands into per-channel parts, gathers half,
// square and x_to_cordic as each part finishes, and hands the bundle on with a watchdog.

// One channel: x/2 by exponent decrement, x*x by an early-terminating shift-add multiply.
// Latency is data dependent: one cycle per mantissa bit down to the lowest set bit.
module stage_one_part #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         start,
  input  logic [W-1:0] x,
  output logic         done,
  output logic [W-1:0] half,
  output logic [W-1:0] square,
  output logic [W-1:0] x_to_cordic
);
  localparam int EW   = (W == 64) ? 11 : (W == 16) ? 5 : 8;
  localparam int MW   = W - 1 - EW;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam logic [EW-1:0]          EMAX   = '1;
  localparam logic signed [EW+2:0]   BIAS_S = (EW + 3)'(BIAS);
  localparam logic signed [EW+2:0]   EMAX_S = (EW + 3)'((1 << EW) - 1);

  logic [W-1:0]      x_reg;
  logic [MW:0]       mult_reg;
  logic [2*MW+1:0]   mcand_reg;
  logic [2*MW+1:0]   acc_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [EW-1:0]     x_e;
  logic              is_num;
  logic [EW-1:0]     e;
  logic              carry;
  logic [MW-1:0]     sq_mant;
  logic signed [EW+2:0] e2;
  logic              unused_bits;

  assign x_e    = x[W-2:MW];
  assign is_num = (x_e != '0) && (x_e != EMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg     <= '0;
      mult_reg  <= '0;
      mcand_reg <= '0;
      acc_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (clk_en) begin
      done_reg <= 1'b0;
      if (start) begin
        x_reg     <= x;
        acc_reg   <= '0;
        busy_reg  <= 1'b1;
        mult_reg  <= is_num ? {1'b1, x[MW-1:0]} : '0;
        mcand_reg <= is_num ? ({{(MW + 1){1'b0}}, 1'b1, x[MW-1:0]} << MW) : '0;
      end else if (busy_reg) begin
        if (mult_reg[MW]) acc_reg <= acc_reg + mcand_reg;
        mult_reg  <= mult_reg << 1;
        mcand_reg <= mcand_reg >> 1;
        // Stop as soon as no set multiplier bits remain below the one just consumed.
        if (mult_reg[MW-1:0] == '0) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign e       = x_reg[W-2:MW];
  assign carry   = acc_reg[2*MW+1];
  assign sq_mant = carry ? acc_reg[2*MW -: MW] : acc_reg[2*MW-1 -: MW];
  assign e2      = $signed({3'b000, e}) + $signed({3'b000, e}) - BIAS_S
                   + $signed({{(EW + 2){1'b0}}, carry});

  always_comb begin
    square = '0;
    if (e == '0)              square = '0;
    else if (e == EMAX)       square = {1'b0, x_reg[W-2:0]};
    else if (e2 >= EMAX_S)    square = {1'b0, EMAX, {MW{1'b0}}};
    else if (e2[EW+2] || e2 == '0) square = '0;
    else                      square = {1'b0, e2[EW-1:0], sq_mant};
  end

  // Denormal results flush to signed zero.
  always_comb begin
    half = x_reg;
    if (e == EMAX)              half = x_reg;
    else if (e <= EW'(1))       half = {x_reg[W-1], {(W - 1){1'b0}}};
    else                        half = {x_reg[W-1], e - EW'(1), x_reg[MW-1:0]};
  end

  assign done        = done_reg;
  assign x_to_cordic = x_reg;
  assign unused_bits = ^acc_reg[MW-1:0];
endmodule

module stage_1_multi #(
  parameter int FLT_DATA_WIDTH = 32,
  parameter int NUM_CH         = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  stage_1_multi_if.slave  bus
);
  localparam int W  = FLT_DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WORKING, FLUSH, DONE} state_t;

  state_t              state_reg, state_next;
  logic [NUM_CH-1:0]   done_mask_reg, done_mask_next;
  logic [NUM_CH-1:0]   part_done, new_done;
  logic [TW-1:0]       timer_reg, timer_next;
  logic                abort_reg, abort_next;
  logic                start_reg, start_next;
  logic                timeout_reg, timeout_next;
  logic                capture;
  logic                part_rst;
  logic [NUM_CH*W-1:0] x_reg;
  logic [NUM_CH*W-1:0] out_x_reg, out_half_reg, out_square_reg;
  logic [NUM_CH*W-1:0] part_half, part_square, part_x;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      stage_one_part #(.W(W)) u_part (
        .clk         (clk),
        .rst         (part_rst),
        .clk_en      (clk_en),
        .start       (start_reg),
        .x           (x_reg[gi*W +: W]),
        .done        (part_done[gi]),
        .half        (part_half[gi*W +: W]),
        .square      (part_square[gi*W +: W]),
        .x_to_cordic (part_x[gi*W +: W])
      );
    end
  endgenerate

  assign part_rst = rst | (state_reg == FLUSH);
  assign new_done = part_done & ~done_mask_reg;

  always_comb begin
    state_next     = state_reg;
    done_mask_next = done_mask_reg;
    timer_next     = timer_reg;
    abort_next     = abort_reg;
    start_next     = 1'b0;
    timeout_next   = 1'b0;
    capture        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          start_next     = 1'b1;
          done_mask_next = '0;
          timer_next     = '0;
          abort_next     = 1'b0;
          state_next     = WORKING;
        end
      end
      WORKING: begin
        capture        = 1'b1;
        done_mask_next = done_mask_reg | part_done;
        timer_next     = timer_reg + TW'(1);
        // Completion on the limit cycle wins over the watchdog.
        if (&done_mask_next) begin
          state_next = FLUSH;
        end else if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_next = 1'b1;
          abort_next   = 1'b1;
          state_next   = FLUSH;
        end
      end
      FLUSH:   state_next = abort_reg ? IDLE : DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      done_mask_reg <= '0;
      timer_reg     <= '0;
      abort_reg     <= 1'b0;
      start_reg     <= 1'b0;
      timeout_reg   <= 1'b0;
      x_reg         <= '0;
    end else if (clk_en) begin
      state_reg     <= state_next;
      done_mask_reg <= done_mask_next;
      timer_reg     <= timer_next;
      abort_reg     <= abort_next;
      start_reg     <= start_next;
      timeout_reg   <= timeout_next;
      if (start_next) x_reg <= bus.x_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_x_reg      <= '0;
      out_half_reg   <= '0;
      out_square_reg <= '0;
    end else if (clk_en && capture) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (new_done[k]) begin
          out_x_reg[k*W +: W]      <= part_x[k*W +: W];
          out_half_reg[k*W +: W]   <= part_half[k*W +: W];
          out_square_reg[k*W +: W] <= part_square[k*W +: W];
        end
      end
    end
  end

  assign bus.in_ready   = (state_reg == IDLE);
  assign bus.out_valid  = (state_reg == DONE);
  assign bus.out_x      = out_x_reg;
  assign bus.out_half   = out_half_reg;
  assign bus.out_square = out_square_reg;
  assign bus.timeout    = timeout_reg;
endmodule
